// File: rtl/fpnew_special_packer.sv
// Special-value packer: turns a requested FP class and a sign into the canonical
// encoding, NaN-boxes it to FLEN bits, and sends it down a valid/ready pipeline.
package fpnew_pkg;
    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signalling;
        logic is_quiet;
        logic is_boxed;
    } fp_info_t;

    function automatic int unsigned exp_bits(fp_format_e f);
        case (f)
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e f);
        case (f)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e f);
        return 1 + exp_bits(f) + man_bits(f);
    endfunction
endpackage

module fpnew_special_packer #(
    parameter fpnew_pkg::fp_format_e FpFormat    = fpnew_pkg::fp_format_e'(0),
    parameter int unsigned           FLEN        = 64,
    parameter int unsigned           NumPipeRegs = 1,
    parameter int unsigned           TagWidth    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [2:0]           class_i,
    input  logic                 sign_i,
    input  logic                 box_i,
    input  logic [TagWidth-1:0]  tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [FLEN-1:0]      result_o,
    output fpnew_pkg::fp_info_t  info_o,
    output logic [TagWidth-1:0]  tag_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);
    localparam int unsigned EXP_BITS = fpnew_pkg::exp_bits(FpFormat);
    localparam int unsigned MAN_BITS = fpnew_pkg::man_bits(FpFormat);
    localparam int unsigned WIDTH    = fpnew_pkg::fp_width(FpFormat);

    typedef enum logic [2:0] {
        CLS_ZERO, CLS_INF, CLS_QNAN, CLS_SNAN,
        CLS_MAX_NORMAL, CLS_MIN_NORMAL, CLS_MIN_SUBNORMAL, CLS_MAX_SUBNORMAL
    } spec_class_e;

    typedef struct packed {
        logic [FLEN-1:0]     result;
        fpnew_pkg::fp_info_t info;
        logic [TagWidth-1:0] tag;
    } payload_t;

    logic [EXP_BITS-1:0] exp_f;
    logic [MAN_BITS-1:0] man_f;
    logic                sgn;
    logic                boxed;
    logic [FLEN-1:0]     enc_result;
    fpnew_pkg::fp_info_t enc_info;
    payload_t            enc;

    always_comb begin
        exp_f = '0;
        man_f = '0;
        sgn   = sign_i;
        case (spec_class_e'(class_i))
            CLS_ZERO:          ;
            CLS_INF:           exp_f = '1;
            CLS_QNAN: begin
                exp_f = '1;
                man_f = {1'b1, {(MAN_BITS-1){1'b0}}};
                sgn   = 1'b0;
            end
            CLS_SNAN: begin
                exp_f = '1;
                man_f = MAN_BITS'(1);
            end
            CLS_MAX_NORMAL: begin
                exp_f = {{(EXP_BITS-1){1'b1}}, 1'b0};
                man_f = '1;
            end
            CLS_MIN_NORMAL:    exp_f = EXP_BITS'(1);
            CLS_MIN_SUBNORMAL: man_f = MAN_BITS'(1);
            CLS_MAX_SUBNORMAL: man_f = '1;
            default:           ;
        endcase
    end

    generate
        if (FLEN > WIDTH) begin : g_box
            assign enc_result = {{(FLEN-WIDTH){box_i}}, sgn, exp_f, man_f};
            assign boxed      = box_i;
        end else begin : g_nobox
            assign enc_result = {sgn, exp_f, man_f};
            assign boxed      = 1'b1;
        end
    endgenerate

    // A value without a valid NaN-box reads back as the canonical quiet NaN.
    always_comb begin
        enc_info = '0;
        if (!boxed) begin
            enc_info.is_nan   = 1'b1;
            enc_info.is_quiet = 1'b1;
        end else begin
            enc_info.is_boxed = 1'b1;
            case (spec_class_e'(class_i))
                CLS_ZERO:          enc_info.is_zero = 1'b1;
                CLS_INF:           enc_info.is_inf  = 1'b1;
                CLS_QNAN: begin
                    enc_info.is_nan   = 1'b1;
                    enc_info.is_quiet = 1'b1;
                end
                CLS_SNAN: begin
                    enc_info.is_nan        = 1'b1;
                    enc_info.is_signalling = 1'b1;
                end
                CLS_MAX_NORMAL,
                CLS_MIN_NORMAL:    enc_info.is_normal    = 1'b1;
                default:           enc_info.is_subnormal = 1'b1;
            endcase
        end
    end

    assign enc = '{result: enc_result, info: enc_info, tag: tag_i};

    generate
        if (NumPipeRegs == 0) begin : g_comb
            assign result_o    = enc.result;
            assign info_o      = enc.info;
            assign tag_o       = enc.tag;
            assign out_valid_o = in_valid_i;
            assign in_ready_o  = out_ready_i;
            assign busy_o      = 1'b0;
        end else begin : g_pipe
            logic [NumPipeRegs-1:0] valid_q;
            payload_t               data_q [NumPipeRegs];
            logic [NumPipeRegs:0]   ready;
            logic [NumPipeRegs-1:0] v_in;
            payload_t               d_in [NumPipeRegs];

            assign ready[NumPipeRegs] = out_ready_i;

            for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
                if (k == 0) begin : g_head
                    assign v_in[k] = in_valid_i;
                    assign d_in[k] = enc;
                end else begin : g_body
                    assign v_in[k] = valid_q[k-1];
                    assign d_in[k] = data_q[k-1];
                end
                // An empty stage always accepts, so bubbles collapse.
                assign ready[k] = ready[k+1] | ~valid_q[k];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= '0;
                    for (int k = 0; k < NumPipeRegs; k++) data_q[k] <= '0;
                end else begin
                    for (int k = 0; k < NumPipeRegs; k++) begin
                        if (flush_i)       valid_q[k] <= 1'b0;
                        else if (ready[k]) valid_q[k] <= v_in[k];
                        if (ready[k] && v_in[k]) data_q[k] <= d_in[k];
                    end
                end
            end

            assign in_ready_o  = ready[0];
            assign out_valid_o = valid_q[NumPipeRegs-1];
            assign result_o    = data_q[NumPipeRegs-1].result;
            assign info_o      = data_q[NumPipeRegs-1].info;
            assign tag_o       = data_q[NumPipeRegs-1].tag;
            assign busy_o      = |valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_fpnew_special_packer.sv
// Bench for fpnew_special_packer: a 1-stage and a 2-stage FP32/FLEN=64 instance
// driven by directed steps, checked against a queue scoreboard and a classifier.
module tb_fpnew_special_packer;
    import fpnew_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]  a_class, b_class;
    logic        a_sign, b_sign, a_box, b_box;
    logic [3:0]  a_tag_in, b_tag_in, a_tag, b_tag;
    logic        a_in_valid, b_in_valid, a_in_ready, b_in_ready;
    logic        a_flush, b_flush;
    logic [63:0] a_result, b_result;
    fp_info_t    a_info, b_info;
    logic        a_out_valid, b_out_valid, a_out_ready, b_out_ready;
    logic        a_busy, b_busy;

    fpnew_special_packer #(.FpFormat(FP32), .FLEN(64), .NumPipeRegs(1), .TagWidth(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .class_i(a_class), .sign_i(a_sign), .box_i(a_box),
        .tag_i(a_tag_in), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .flush_i(a_flush),
        .result_o(a_result), .info_o(a_info), .tag_o(a_tag), .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready), .busy_o(a_busy));

    fpnew_special_packer #(.FpFormat(FP32), .FLEN(64), .NumPipeRegs(2), .TagWidth(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .class_i(b_class), .sign_i(b_sign), .box_i(b_box),
        .tag_i(b_tag_in), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .flush_i(b_flush),
        .result_o(b_result), .info_o(b_info), .tag_o(b_tag), .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready), .busy_o(b_busy));

    typedef struct {
        logic [63:0] res;
        fp_info_t    info;
        logic [3:0]  tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] c, input logic s, input logic b);
        logic [31:0] w;
        case (c)
            3'd0:    w = 32'h0000_0000;
            3'd1:    w = 32'h7F80_0000;
            3'd2:    w = 32'h7FC0_0000;
            3'd3:    w = 32'h7F80_0001;
            3'd4:    w = 32'h7F7F_FFFF;
            3'd5:    w = 32'h0080_0000;
            3'd6:    w = 32'h0000_0001;
            default: w = 32'h007F_FFFF;
        endcase
        if (c != 3'd2) w[31] = s;
        return {(b ? 32'hFFFF_FFFF : 32'h0000_0000), w};
    endfunction

    // Reference classifier applied to the 64-bit register value.
    function automatic fp_info_t classify(input logic [63:0] r);
        fp_info_t    i;
        logic [7:0]  e;
        logic [22:0] m;
        i = '0;
        e = r[30:23];
        m = r[22:0];
        if (r[63:32] != 32'hFFFF_FFFF) begin
            i.is_nan   = 1'b1;
            i.is_quiet = 1'b1;
        end else begin
            i.is_boxed = 1'b1;
            if (e == 8'h00) begin
                if (m == 23'd0) i.is_zero = 1'b1;
                else            i.is_subnormal = 1'b1;
            end else if (e == 8'hFF) begin
                if (m == 23'd0) i.is_inf = 1'b1;
                else begin
                    i.is_nan = 1'b1;
                    if (m[22]) i.is_quiet = 1'b1;
                    else       i.is_signalling = 1'b1;
                end
            end else i.is_normal = 1'b1;
        end
        return i;
    endfunction

    function automatic exp_t mk(input logic [2:0] c, input logic s, input logic b, input logic [3:0] t);
        exp_t e;
        e.res  = model(c, s, b);
        e.info = classify(e.res);
        e.tag  = t;
        return e;
    endfunction

    // Pop on output handshake, push on input handshake (flushed inputs are dropped).
    exp_t ea, eb;
    always @(negedge clk) if (rst_n) begin
        if (a_out_valid && a_out_ready) begin
            chk("a_out_expected", 128'(qa.size() != 0), 128'd1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_result", a_result, ea.res);
                chk("a_info", a_info, ea.info);
                chk("a_tag", a_tag, ea.tag);
            end
        end
        if (a_in_valid && a_in_ready && !a_flush) qa.push_back(mk(a_class, a_sign, a_box, a_tag_in));
        if (b_out_valid && b_out_ready) begin
            chk("b_out_expected", 128'(qb.size() != 0), 128'd1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_result", b_result, eb.res);
                chk("b_info", b_info, eb.info);
                chk("b_tag", b_tag, eb.tag);
            end
        end
        if (b_in_valid && b_in_ready && !b_flush) qb.push_back(mk(b_class, b_sign, b_box, b_tag_in));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [63:0] held;
    logic [3:0]  t;

    initial begin
        rst_n = 1'b0;
        a_class = '0; a_sign = 0; a_box = 0; a_tag_in = '0; a_in_valid = 0; a_flush = 0; a_out_ready = 1;
        b_class = '0; b_sign = 0; b_box = 0; b_tag_in = '0; b_in_valid = 0; b_flush = 0; b_out_ready = 1;
        #3;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_a_result", a_result, 0);
        chk("rst_a_info", a_info, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_busy", b_busy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Signed zero, boxed, one-cycle latency.
        a_class = 3'd0; a_sign = 1; a_box = 1; a_tag_in = 4'd1; a_in_valid = 1;
        chk("lat_a_pre_valid", a_out_valid, 0);
        step();
        a_in_valid = 0;
        chk("lat_a_valid", a_out_valid, 1);
        chk("zero_result", a_result, 64'hFFFF_FFFF_8000_0000);
        chk("zero_is_zero", a_info.is_zero, 1);
        chk("zero_is_boxed", a_info.is_boxed, 1);
        step();

        // Full sweep back-to-back: every class/sign/box at one entry per cycle.
        t = 4'd0;
        a_in_valid = 1;
        for (int c = 0; c < 8; c++)
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 2; b++) begin
                    a_class = c[2:0]; a_sign = s[0]; a_box = b[0]; a_tag_in = t;
                    t = t + 4'd1;
                    chk("sweep_in_ready", a_in_ready, 1);
                    step();
                    chk("sweep_out_valid", a_out_valid, 1);
                end
        a_in_valid = 0;
        repeat (2) step();

        // Stall the 2-stage instance for 5 cycles while issuing tags 1,2,3.
        b_out_ready = 0; b_sign = 1; b_box = 1;
        b_in_valid = 1; b_tag_in = 4'd1; b_class = 3'd1;
        step();
        chk("stall_ready_after1", b_in_ready, 1);
        b_tag_in = 4'd2; b_class = 3'd2;
        step();
        chk("stall_ready_after2", b_in_ready, 0);
        chk("stall_out_valid", b_out_valid, 1);
        chk("stall_head_tag", b_tag, 4'd1);
        held = b_result;
        b_tag_in = 4'd3; b_class = 3'd3;
        repeat (3) begin
            step();
            chk("stall_ready_held", b_in_ready, 0);
            chk("stall_tag_stable", b_tag, 4'd1);
            chk("stall_result_stable", b_result, held);
        end
        b_out_ready = 1;
        #1 chk("release_in_ready", b_in_ready, 1);
        step();
        b_in_valid = 0;
        repeat (4) step();
        chk("stall_queue_drained", 128'(qb.size()), 128'd0);

        // Flush with two entries in flight and a concurrent input handshake.
        b_in_valid = 1; b_tag_in = 4'd4; b_class = 3'd5;
        step();
        b_tag_in = 4'd5; b_class = 3'd6;
        step();
        b_tag_in = 4'd6; b_class = 3'd7; b_flush = 1;
        step();
        b_flush = 0; b_in_valid = 0;
        qb.delete();
        chk("flush_out_valid", b_out_valid, 0);
        chk("flush_busy", b_busy, 0);
        chk("flush_in_ready", b_in_ready, 1);
        repeat (3) begin
            step();
            chk("flush_stays_empty", b_out_valid, 0);
        end

        // Asynchronous reset while an entry sits stalled at the output.
        b_out_ready = 0; b_in_valid = 1; b_tag_in = 4'd7; b_class = 3'd3;
        step();
        b_in_valid = 0;
        step();
        chk("pre_rst_out_valid", b_out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", b_out_valid, 0);
        chk("arst_result", b_result, 0);
        chk("arst_busy", b_busy, 0);
        chk("arst_in_ready", b_in_ready, 1);
        qa.delete();
        qb.delete();
        step();
        rst_n = 1'b1;
        b_out_ready = 1; b_in_valid = 1; b_tag_in = 4'd8; b_class = 3'd1; b_sign = 1; b_box = 0;
        step();
        b_in_valid = 0;
        chk("post_rst_lat1", b_out_valid, 0);
        step();
        chk("post_rst_lat2", b_out_valid, 1);
        chk("post_rst_tag", b_tag, 4'd8);
        chk("post_rst_unboxed", b_result, 64'h0000_0000_FF80_0000);
        repeat (3) step();
        chk("final_qa_empty", 128'(qa.size()), 128'd0);
        chk("final_qb_empty", 128'(qb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpnew_special_packer.md
Name: fpnew_special_packer

Overview:
- Inverse of the operand classifier: takes a requested FP class code plus sign and produces the canonical bit pattern for that class in format FpFormat.
- Result is NaN-boxed into an FLEN-wide register value, together with the matching fp_info_t.
- Used by the FPU to inject special results (canonical NaN, signed zero/inf, overflow max-normal, underflow subnormals) into the writeback path.
- Valid/ready pipelined with a configurable number of register stages, a tag passthrough and a flush.

Parameters:
- FpFormat, fpnew_pkg::fp_format_e'(0) (FP32), target format; WIDTH/EXP_BITS/MAN_BITS derived via fpnew_pkg.
- FLEN, 64, output register width; must be >= WIDTH.
- NumPipeRegs, 1, register stages between input and output; 0 = combinational path.
- TagWidth, 4, width of opaque tag carried alongside the result.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- class_i  in  3  requested class code (encoding below).
- sign_i  in  1  requested sign.
- box_i  in  1  1 = NaN-box upper FLEN-WIDTH bits with ones; 0 = fill with zeros.
- tag_i  in  TagWidth  opaque tag.
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input ready.
- flush_i  in  1  synchronous kill of all in-flight entries.
- result_o  out  FLEN  packed value.
- info_o  out  fpnew_pkg::fp_info_t  classification of result_o.
- tag_o  out  TagWidth  tag of the output entry.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  any stage holds a valid entry.

Behaviour:
- Class encoding: 0 ZERO, 1 INF, 2 QNAN, 3 SNAN, 4 MAX_NORMAL, 5 MIN_NORMAL, 6 MIN_SUBNORMAL, 7 MAX_SUBNORMAL.
- Bit patterns (exp / man):
  - ZERO: 0 / 0.
  - INF: all-ones / 0.
  - QNAN: all-ones / MSB=1, rest 0; sign forced to 0 (canonical NaN), sign_i ignored.
  - SNAN: all-ones / LSB=1, MSB=0.
  - MAX_NORMAL: all-ones minus 1 / all-ones.
  - MIN_NORMAL: 1 / 0.
  - MIN_SUBNORMAL: 0 / 1.
  - MAX_SUBNORMAL: 0 / all-ones.
  - All classes except QNAN use sign_i.
- Boxing: result_o[WIDTH-1:0] = packed value. result_o[FLEN-1:WIDTH] = all ones if box_i, else all zeros. Boxing fields absent when FLEN==WIDTH.
- info_o: must equal what the classifier reports for result_o with is_boxed = (box_i || FLEN==WIDTH).
  - Unboxed: is_nan=1, is_quiet=1, all other flags 0.
  - Exactly one of normal/subnormal/zero/inf/nan set when boxed.
  - is_signalling only for SNAN; is_quiet only for QNAN or unboxed.
- Encoding and info are computed combinationally before stage 0; the registers carry result, info and tag.
- Pipeline (NumPipeRegs>=1): stage k holds valid_q[k].
  - Stage k accepts when ready[k] = ready[k+1] || !valid_q[k], with ready[last+1] = out_ready_i.
  - Bubbles collapse.
  - in_ready_o = ready[0]; out_valid_o = valid_q[last].
- Latency NumPipeRegs cycles with no stall; full throughput of 1 entry/cycle with out_ready_i held at 1.
- Data registers load only on the accepting handshake. Outputs are stable while out_valid_o=1 and out_ready_i=0.
- NumPipeRegs=0: all outputs combinational from the inputs; in_ready_o = out_ready_i; flush_i has no effect.
- flush_i: all valid_q clear at the next edge; in_ready_o unaffected. An input handshake in the same cycle as flush_i is discarded. Data registers are not cleared.
- busy_o = OR of valid_q (0 when NumPipeRegs=0).
- Reset (async, any time including mid-transfer): all valid_q=0; result/info/tag registers=0; out_valid_o=0, busy_o=0, in_ready_o=1 (when out_ready_i or stages empty).
- Class codes cover all 3-bit values; no illegal input.

Test Plan:
- FP32, FLEN=64, NumPipeRegs=1: class=0, sign=1, box=1 → one cycle later result_o=0xFFFFFFFF_80000000, info is_zero=1, is_boxed=1.
- Sweep with sign=0, box=1:
  - INF → 0x…7F800000.
  - QNAN with sign_i=1 → 0x…7FC00000, is_quiet=1.
  - SNAN → 0x…7F800001, is_signalling=1.
  - MAX_NORMAL → 0x…7F7FFFFF.
  - MIN_SUBNORMAL → 0x…00000001, is_subnormal=1.
- box=0, class=1 → result_o=0x00000000_7F800000, info is_nan=1, is_quiet=1, is_boxed=0. Feeding result_o through the classifier must match info_o for every class/sign/box combination.
- NumPipeRegs=2, out_ready_i=0 for 5 cycles while issuing 3 tagged entries:
  - in_ready_o drops after 2 accepted entries and the 3rd is held.
  - On release, tags emerge in order 1,2,3 with no loss or duplication.
- Two entries in flight, assert flush_i with a concurrent input handshake → next cycle out_valid_o=0, busy_o=0; the concurrent entry never appears.
- Deassert rst_ni mid-stall with out_valid_o=1 → out_valid_o=0, result_o=0, busy_o=0 immediately (asynchronous). After release, a new entry completes with nominal latency.
